// File: rtl/vga_bus_responder_if.sv
// Motherboard-to-VGA request/acknowledge bus bundle.
// The motherboard side drives the request pins, address and write data;
// the VGA responder drives the status word and read data back.

`ifndef WORD_WIDTH
`define WORD_WIDTH 32
`endif

interface vga_bus_responder_if #(
    parameter int word_width = `WORD_WIDTH
);
    logic [word_width-1:0] vga_ctrl;
    logic [word_width-1:0] vga_stat;
    logic [word_width-1:0] addr;
    logic [word_width-1:0] data_in;
    logic [word_width-1:0] data_out;

    modport master (
        output vga_ctrl,
        output addr,
        output data_in,
        input  vga_stat,
        input  data_out
    );

    modport slave (
        input  vga_ctrl,
        input  addr,
        input  data_in,
        output vga_stat,
        output data_out
    );
endinterface

// File: rtl/vga_bus_responder.sv
// VGA-side responder for the motherboard request/acknowledge handshake.
// Latches one word read or write, performs it on the single-port
// framebuffer RAM whenever the scan-out engine leaves the port free, and
// holds the acknowledge until the motherboard releases both request pins.
// Scan-out reads always win the RAM port.

`ifndef WORD_WIDTH
`define WORD_WIDTH 32
`endif
`ifndef VGA_WRITE_PIN
`define VGA_WRITE_PIN 0
`endif
`ifndef VGA_READ_PIN
`define VGA_READ_PIN 1
`endif
`ifndef VGA_ACK
`define VGA_ACK 0
`endif
`ifndef VGA_ERR
`define VGA_ERR 1
`endif

module vga_bus_responder #(
    parameter int word_width    = `WORD_WIDTH,
    parameter int fb_depth      = 4096,
    parameter int fb_addr_width = 12
) (
    input  logic                     clk,
    input  logic                     rst_n,
    vga_bus_responder_if.slave       bus,
    input  logic                     scan_req,
    input  logic [fb_addr_width-1:0] scan_addr,
    output logic [word_width-1:0]    scan_data,
    output logic                     scan_valid
);

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        ACK
    } state_t;

    localparam logic [word_width-1:0] depth_limit = word_width'(fb_depth);

    state_t                   state;
    state_t                   state_next;
    logic                     write_pin;
    logic                     read_pin;
    logic                     accept;
    logic                     both_err;
    logic                     access;
    logic                     req_write;
    logic [word_width-1:0]    req_addr;
    logic [word_width-1:0]    req_data;
    logic [word_width-1:0]    data_reg;
    logic                     err;
    logic                     in_range;
    logic [fb_addr_width-1:0] ram_addr;
    logic [word_width-1:0]    ram_rdata;
    logic                     ram_we;
    logic                     unused_ctrl_bits;
    logic [word_width-1:0]    mem [fb_depth];

    assign write_pin        = bus.vga_ctrl[`VGA_WRITE_PIN];
    assign read_pin         = bus.vga_ctrl[`VGA_READ_PIN];
    // Only two pins of the control word matter; the rest are don't-care.
    assign unused_ctrl_bits = ^bus.vga_ctrl;

    // The full address is range-checked, so aliasing upper bits never hit RAM.
    assign in_range  = req_addr < depth_limit;
    // Scan-out owns the port whenever it asks for it.
    assign ram_addr  = scan_req ? scan_addr : req_addr[fb_addr_width-1:0];
    assign ram_rdata = mem[ram_addr];
    assign ram_we    = access && req_write && in_range;

    assign bus.data_out = data_reg;

    // Status word: acknowledge follows the state, error is sticky, rest zero.
    always_comb begin
        bus.vga_stat           = '0;
        bus.vga_stat[`VGA_ACK] = (state == ACK);
        bus.vga_stat[`VGA_ERR] = err;
    end

    // Handshake state register; reset in ACK drops the acknowledge at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and one-cycle strobes for latching, errors and RAM access.
    always_comb begin
        state_next = state;
        accept     = 1'b0;
        both_err   = 1'b0;
        access     = 1'b0;
        case (state)
            IDLE: begin
                if (write_pin ^ read_pin) begin
                    accept     = 1'b1;
                    state_next = ACCESS;
                end else if (write_pin && read_pin) begin
                    both_err   = 1'b1;
                    state_next = ACK;
                end
            end
            ACCESS: begin
                if (!scan_req) begin
                    access     = 1'b1;
                    state_next = ACK;
                end
            end
            ACK: begin
                if (!write_pin && !read_pin) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Latched request, read-data register and sticky error flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_write <= 1'b0;
            req_addr  <= '0;
            req_data  <= '0;
            data_reg  <= '0;
            err       <= 1'b0;
        end else begin
            if (accept) begin
                req_write <= write_pin;
                req_addr  <= bus.addr;
                req_data  <= bus.data_in;
            end
            if (both_err) begin
                err      <= 1'b1;
                data_reg <= '0;
            end
            if (access) begin
                if (!in_range) begin
                    err <= 1'b1;
                end
                if (!req_write) begin
                    data_reg <= in_range ? ram_rdata : '0;
                end
            end
        end
    end

    // Scan-out read: data and valid appear the cycle after the request.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scan_valid <= 1'b0;
            scan_data  <= '0;
        end else begin
            scan_valid <= scan_req;
            if (scan_req) begin
                scan_data <= ram_rdata;
            end
        end
    end

    // Framebuffer write port; contents are deliberately not reset.
    always_ff @(posedge clk) begin
        if (ram_we) begin
            mem[ram_addr] <= req_data;
        end
    end

endmodule
